// File: rtl/spi_ram_master.sv
// spi_ram_master: SPI initiator that frames 10-bit RAM commands and captures read-data replies
// Ports: clk/rst (async active-high); cmd_valid/cmd_ready/cmd_data command intake;
// rd_valid/rd_data captured reply byte; busy frame in progress; SS_n/MOSI/MISO serial link.
module spi_ram_master #(
  parameter int RD_GAP = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {IDLE, START, SHIFT, GAP, RECV, STOP} state_t;
  state_t state;
  logic [9:0] sh;
  logic [3:0] cnt;
  logic [7:0] rx;
  logic       rd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      rx <= '0;
      rd <= 1'b0;
      cmd_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      busy <= 1'b0;
      SS_n <= 1'b1;
      MOSI <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            sh <= cmd_data;
            rd <= &cmd_data[9:8];
            cmd_ready <= 1'b0;
            busy <= 1'b1;
            SS_n <= 1'b0;
            state <= START;
          end
        end
        // START is the slave's check cycle; the first bit is driven as it ends
        START: begin
          MOSI <= sh[9];
          sh <= {sh[8:0], 1'b0};
          cnt <= 4'd9;
          state <= SHIFT;
        end
        SHIFT:
          if (cnt == 4'd0) begin
            MOSI <= 1'b0;
            state <= rd ? GAP : STOP;
            SS_n <= ~rd;
            cnt <= rd ? 4'(RD_GAP - 1) : 4'(IDLE_GAP - 1);
          end else begin
            MOSI <= sh[9];
            sh <= {sh[8:0], 1'b0};
            cnt <= cnt - 4'd1;
          end
        GAP:
          if (cnt == 4'd0) begin
            cnt <= 4'd7;
            state <= RECV;
          end else
            cnt <= cnt - 4'd1;
        RECV: begin
          rx <= {rx[6:0], MISO};
          if (cnt == 4'd0) begin
            rd_data <= {rx[6:0], MISO};
            rd_valid <= 1'b1;
            SS_n <= 1'b1;
            cnt <= 4'(IDLE_GAP - 1);
            state <= STOP;
          end else
            cnt <= cnt - 4'd1;
        end
        STOP:
          if (cnt == 4'd0) begin
            cmd_ready <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else
            cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: randomized scoreboard bench with a serial slave+RAM model
module tb_spi_ram_master;
  localparam int RD_GAP = 2;
  localparam int IDLE_GAP = 1;
  logic clk = 0, rst = 1, cmd_valid = 0, MISO = 0;
  logic [9:0] cmd_data = '0;
  logic cmd_ready, rd_valid, busy, SS_n, MOSI;
  logic [7:0] rd_data;
  spi_ram_master #(.RD_GAP(RD_GAP), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  logic [9:0] fq[$];
  logic [7:0] rdq[$];
  int rtq[$];
  logic [7:0] ref_ram[256];
  logic [7:0] wa = 0, ra = 0;
  int prev_acc = 0;
  logic have_prev = 0, prev_rd = 0, held = 0, b2b = 0;
  initial foreach (ref_ram[i]) ref_ram[i] = 8'h00;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      fq.delete(); rdq.delete(); rtq.delete();
      have_prev = 0; held = 0; b2b = 0;
    end else begin
      if (!cmd_valid) held = 0;
      if (cmd_valid && cmd_ready) begin
        if (have_prev && held) begin
          check("accept_spacing", cyc - prev_acc, prev_rd ? 20 + RD_GAP + IDLE_GAP : 12 + IDLE_GAP);
          b2b = 1;
        end else b2b = 0;
        have_prev = 1; held = 1; prev_acc = cyc; prev_rd = &cmd_data[9:8];
        fq.push_back(cmd_data);
        case (cmd_data[9:8])
          2'b00: wa = cmd_data[7:0];
          2'b01: ref_ram[wa] = cmd_data[7:0];
          2'b10: ra = cmd_data[7:0];
          default: begin
            rdq.push_back(ref_ram[ra]);
            rtq.push_back(cyc + 19 + RD_GAP);
          end
        endcase
      end
    end
  end
  int n = 0, hi = 0;
  logic [9:0] fr = '0, e;
  logic [7:0] s_ram[256];
  logic [7:0] s_wa = 0, s_ra = 0, b;
  initial foreach (s_ram[i]) s_ram[i] = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      n = 0; hi = 0;
    end else if (!SS_n) begin
      if (n == 0) begin
        if (b2b) check("ss_high_gap", hi, IDLE_GAP + 1);
        else check("ss_high_min", hi >= IDLE_GAP, 1);
        fr = '0;
      end
      check("busy_in_frame", busy, 1);
      if (n == 0 || n > 10) check("mosi_quiet", MOSI, 0);
      else fr = {fr[8:0], MOSI};
      if (n >= 11 && fr[9:8] == 2'b11) begin
        if (n - 11 - RD_GAP >= 0 && n - 11 - RD_GAP < 8) begin
          b = s_ram[s_ra];
          MISO = b[7 - (n - 11 - RD_GAP)];
        end else MISO = 1'($urandom);
      end
      n++; hi = 0;
    end else begin
      if (n > 0) begin
        if (fq.size() == 0) check("frame_unexpected", 0, 1);
        else begin
          e = fq.pop_front();
          check("frame_bits", fr, e);
          check("frame_len", n, e[9:8] == 2'b11 ? 19 + RD_GAP : 11);
        end
        case (fr[9:8])
          2'b00: s_wa = fr[7:0];
          2'b01: s_ram[s_wa] = fr[7:0];
          2'b10: s_ra = fr[7:0];
          default: ;
        endcase
        n = 0;
      end
      hi++;
      MISO = 1'($urandom);
    end
  end
  logic [7:0] last = 0;
  always @(negedge clk)
    if (rst) last = 0;
    else begin
      if (cmd_ready) check("idle_not_busy", busy, 0);
      if (rd_valid) begin
        if (rdq.size() == 0) check("rd_unexpected", 0, 1);
        else begin
          check("rd_data", rd_data, rdq.pop_front());
          check("rd_time", cyc, rtq.pop_front());
        end
        last = rd_data;
      end else check("rd_hold", rd_data, last);
    end
  task automatic send(input logic [9:0] d);
    int t = 0;
    cmd_valid = 1;
    cmd_data = d;
    do begin
      @(posedge clk);
      t++;
    end while (!cmd_ready && t < 200);
    if (!cmd_ready) check("send_timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic idle(input int g);
    cmd_valid = 0;
    repeat (g) @(negedge clk);
  endtask
  task automatic drain();
    int t = 0;
    cmd_valid = 0;
    while ((fq.size() != 0 || rdq.size() != 0 || !cmd_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < 500, 1);
  endtask
  initial begin
    logic [1:0] op;
    int t;
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    #1 check("ready_at_release", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);
    send(10'b00_1010_0101);
    idle(3);
    send({2'b00, 8'h12});
    send({2'b01, 8'hA5});
    send({2'b10, 8'h12});
    send({2'b11, 8'h00});
    idle(2);
    send({2'b00, 8'h34});
    send({2'b01, 8'h81});
    send({2'b10, 8'h34});
    send({2'b11, 8'h00});
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      send({op, op[0] ? 8'($urandom) : 8'($urandom_range(0, 7))});
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
    end
    drain();
    send({2'b11, 8'h00});
    cmd_valid = 0;
    t = 0;
    while (n != 11 + RD_GAP + 4 && t < 100) begin
      @(negedge clk);
      #1 t++;
    end
    check("reach_recv", n, 11 + RD_GAP + 4);
    rst = 1;
    #1;
    check("abort_ss_n", SS_n, 1);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_data", rd_data, 0);
    check("abort_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("ready_after_abort", cmd_ready, 1);
    send({2'b10, 8'h12});
    send({2'b11, 8'h00});
    send({2'b00, 8'h05});
    send({2'b01, 8'h5A});
    send({2'b10, 8'h05});
    send({2'b11, 8'h00});
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
